cla_seq_addsub_ov: RTL and testbench

- Parametrised, multi-cycle add/subtract unit with signed-overflow and carry-out flags.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, reusing one CHUNK-bit carry-lookahead slice.
- Trades latency for area in the factorial datapath; used where a full-width combinational CLA chain is too large or too slow.
- Uses a start/done handshake toward the controlling FSM.

---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_slice.sv | 41 ++++
 rtl/cla_seq_addsub_ov.sv | 133 +++++++++++++
 tb/tb_cla_seq_addsub_ov.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead add/sub unit.
// Holds the FSM state encoding and a counter-width helper.
package cla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a single-chunk counter still has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead slice.
// Also exposes the carry into its MSB for signed-overflow detection.
module cla_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is the flat sum of generate terms propagated up to bit i.
    always_comb begin
        logic t;
        c = '0;
        t = 1'b0;
        for (int i = 0; i <= CHUNK; i++) begin
            for (int j = -1; j < i; j++) begin
                t = (j < 0) ? ci : g[j];
                for (int k = j + 1; k < i; k++) begin
                    t = t & p[k];
                end
                c[i] = c[i] | t;
            end
        end
    end

    assign s     = p ^ c[CHUNK-1:0];
    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/cla_seq_addsub_ov.sv
// Multi-cycle add/subtract: one CHUNK-bit CLA slice reused per clock.
// Start/done handshake; carry-out and signed overflow on the last slice.
module cla_seq_addsub_ov
    import cla_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co,
    output logic             o_ov
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2(NCHUNK);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ov_q;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] sl_s;
    logic             sl_co;
    logic             sl_cmsb;

    assign last = (cnt_q == CW'(NCHUNK - 1));

    // Select the operand chunk addressed by the counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[k*CHUNK +: CHUNK];
                b_sl = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    cla_slice #(
        .CHUNK(CHUNK)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .ci   (carry_q),
        .s    (sl_s),
        .co   (sl_co),
        .c_msb(sl_cmsb)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, start acceptance and status outputs.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                accept = i_start;
                if (i_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                accept  = i_start;
                state_d = i_start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, per-slice accumulation and final flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= i_a;
            b_q     <= i_b ^ {WIDTH{i_sub}};
            carry_q <= i_sub;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (state_q == ST_RUN) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt_q == CW'(k)) s_q[k*CHUNK +: CHUNK] <= sl_s;
            end
            carry_q <= sl_co;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                co_q <= sl_co;
                ov_q <= sl_cmsb ^ sl_co;
            end
        end
    end

    assign o_s  = s_q;
    assign o_co = co_q;
    assign o_ov = ov_q;

endmodule

// File: tb/tb_cla_seq_addsub_ov.sv
// Self-checking bench for cla_seq_addsub_ov (64/4 and 8/8 instances).
// Reference model uses plain wide arithmetic and two's-complement rules.
module tb_cla_seq_addsub_ov;

    localparam int W = 64;
    localparam int C = 4;
    localparam int N = W / C;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_sub = 1'b0;
    logic [W-1:0]  i_a = '0;
    logic [W-1:0]  i_b = '0;
    logic          o_busy, o_done, o_co, o_ov;
    logic [W-1:0]  o_s;

    logic          s8_start = 1'b0;
    logic          s8_sub = 1'b0;
    logic [7:0]    s8_a = '0;
    logic [7:0]    s8_b = '0;
    logic          o8_busy, o8_done, o8_co, o8_ov;
    logic [7:0]    o8_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_seq_addsub_ov #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_sub(i_sub),
        .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done),
        .o_s(o_s), .o_co(o_co), .o_ov(o_ov)
    );

    cla_seq_addsub_ov #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .reset(reset), .i_start(s8_start), .i_sub(s8_sub),
        .i_a(s8_a), .i_b(s8_b), .o_busy(o8_busy), .o_done(o8_done),
        .o_s(o8_s), .o_co(o8_co), .o_ov(o8_ov)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input int w, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic sub,
                                   output logic [63:0] s, output logic co,
                                   output logic ov);
        logic [64:0] sum;
        logic [63:0] mask, a, b;
        logic        sa, sb, ss;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (sub) begin
            s  = (a - b) & mask;
            co = (a >= b);
        end else begin
            sum = {1'b0, a} + {1'b0, b};
            s   = sum[63:0] & mask;
            co  = sum[w];
        end
        sa = a[w-1];
        sb = b[w-1];
        ss = s[w-1];
        ov = sub ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_done(output int n, output int nb);
        n = 0;
        nb = 0;
        while (!o_done && n < 200) begin
            if (o_busy) nb++;
            tick;
            n++;
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input string tag);
        logic [63:0] es;
        logic        eco, eov;
        int          n, nb;
        ref_op(W, a, b, sub, es, eco, eov);
        i_a = a; i_b = b; i_sub = sub; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        i_a = rnd64(); i_b = rnd64(); i_sub = 1'($urandom);
        wait_done(n, nb);
        check({tag, ".lat"}, 64'(n), 64'(N));
        check({tag, ".busy"}, 64'(nb), 64'(N));
        check({tag, ".s"}, o_s, es);
        check({tag, ".co"}, 64'(o_co), 64'(eco));
        check({tag, ".ov"}, 64'(o_ov), 64'(eov));
        tick;
        check({tag, ".pulse"}, 64'(o_done), 64'd0);
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input string tag);
        logic [63:0] es;
        logic        eco, eov;
        int          n;
        ref_op(8, 64'(a), 64'(b), sub, es, eco, eov);
        s8_a = a; s8_b = b; s8_sub = sub; s8_start = 1'b1;
        tick;
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom);
        n = 0;
        while (!o8_done && n < 50) begin
            tick;
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'd1);
        check({tag, ".s"}, 64'(o8_s), es);
        check({tag, ".co"}, 64'(o8_co), 64'(eco));
        check({tag, ".ov"}, 64'(o8_ov), 64'(eov));
        tick;
    endtask

    initial begin
        int n, nb, cnt;
        logic [63:0] es, es2;
        logic        eco, eov, eco2, eov2;

        // reset state
        tick; tick;
        check("rst.s", o_s, 64'd0);
        check("rst.busy", 64'(o_busy), 64'd0);
        check("rst.done", 64'(o_done), 64'd0);
        check("rst.co", 64'(o_co), 64'd0);
        check("rst.ov", 64'(o_ov), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick;

        // directed corner operations
        run_op(64'd1, 64'd1, 1'b0, "add1p1");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_ov");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_co");
        run_op(64'd0, 64'd1, 1'b1, "sub0m1");
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, "sub_ov");

        // second start during busy is ignored
        ref_op(W, 64'h1234, 64'h0FF0, 1'b0, es, eco, eov);
        i_a = 64'h1234; i_b = 64'h0FF0; i_sub = 1'b0; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        check("ign.clr_s", o_s, 64'd0);
        check("ign.clr_co", 64'(o_co), 64'd0);
        check("ign.clr_ov", 64'(o_ov), 64'd0);
        repeat (4) tick;
        i_a = rnd64(); i_b = rnd64(); i_sub = 1'b1; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        wait_done(n, nb);
        check("ign.lat", 64'(n + 5), 64'(N));
        check("ign.s", o_s, es);
        tick;
        cnt = 0;
        repeat (25) begin
            if (o_done || o_busy) cnt++;
            tick;
        end
        check("ign.single", 64'(cnt), 64'd0);

        // reset mid-operation aborts with no done
        i_a = 64'd5; i_b = 64'd6; i_sub = 1'b0; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        repeat (7) tick;
        reset = 1'b1;
        #1;
        check("abort.s", o_s, 64'd0);
        check("abort.busy", 64'(o_busy), 64'd0);
        check("abort.done", 64'(o_done), 64'd0);
        check("abort.co", 64'(o_co), 64'd0);
        tick;
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            if (o_done) cnt++;
            tick;
        end
        check("abort.nodone", 64'(cnt), 64'd0);
        run_op(64'd3, 64'd4, 1'b0, "after_abort");

        // back-to-back with start held through DONE
        ref_op(W, 64'hDEAD_BEEF, 64'h1111, 1'b0, es, eco, eov);
        ref_op(W, 64'h10, 64'h20, 1'b1, es2, eco2, eov2);
        i_a = 64'hDEAD_BEEF; i_b = 64'h1111; i_sub = 1'b0; i_start = 1'b1;
        tick;
        i_a = 64'h10; i_b = 64'h20; i_sub = 1'b1;
        wait_done(n, nb);
        check("b2b.lat1", 64'(n), 64'(N));
        check("b2b.s1", o_s, es);
        tick;
        i_start = 1'b0;
        n = 1;
        while (!o_done && n < 200) begin
            tick;
            n++;
        end
        check("b2b.gap", 64'(n), 64'(N + 1));
        check("b2b.s2", o_s, es2);
        check("b2b.co2", 64'(o_co), 64'(eco2));
        check("b2b.ov2", 64'(o_ov), 64'(eov2));
        tick;

        // randomized operations
        for (int i = 0; i < 20; i++) begin
            run_op(rnd64(), rnd64(), 1'($urandom), "rnd");
        end

        // single-chunk instance
        run_op8(8'h80, 8'h01, 1'b1, "w8_sub_ov");
        for (int i = 0; i < 8; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), "w8_rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
